sp_bank_responder: RTL and testbench

- Bank-side responder for one scratchpad bank; the memory end of the bank access FSM's write FIFO (wFIFO) and read-request FIFO (rFIFO).
- Pops write and read requests from the two show-ahead FIFOs and drives a single-port SRAM bank with a fixed read latency.
- Returns read rows, with their tags, on a valid/ready response channel.
- Sits between the bank access FSM's FIFOs and the SRAM macro, one instance per bank.

---
 rtl/sp_bank_responder.sv | 156 +++++++++++++++
 tb/tb_sp_bank_responder.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sp_bank_responder.sv
// Memory end of one scratchpad bank: arbitrates the write FIFO and read-request FIFO
// onto a single-port SRAM and returns read rows with their tags on a valid/ready channel.
module sp_bank_responder #(
    parameter int ROW_S_W      = 5,
    parameter int BITS_PER_ROW = 64,
    parameter int TAG_W        = 4,
    parameter int SRAM_LAT     = 2
) (
    input  logic                    CLK,
    input  logic                    nRST,

    input  logic                    wFIFO_empty,
    input  logic [ROW_S_W-1:0]      wFIFO_row,
    input  logic [BITS_PER_ROW-1:0] wFIFO_data,
    output logic                    wFIFO_REN,

    input  logic                    rFIFO_empty,
    input  logic [ROW_S_W-1:0]      rFIFO_row,
    input  logic [TAG_W-1:0]        rFIFO_tag,
    output logic                    rFIFO_REN,

    output logic                    bank_en,
    output logic                    bank_wen,
    output logic [ROW_S_W-1:0]      bank_row,
    output logic [BITS_PER_ROW-1:0] bank_wdata,
    input  logic [BITS_PER_ROW-1:0] bank_rdata,

    output logic                    rsp_valid,
    output logic [BITS_PER_ROW-1:0] rsp_data,
    output logic [TAG_W-1:0]        rsp_tag,
    input  logic                    rsp_ready,

    output logic                    busy
);

    typedef enum logic [2:0] {
        IDLE,
        WRITE,
        READ_ISSUE,
        READ_WAIT,
        RESP
    } stateT;

    typedef enum logic {
        GRANT_WRITE,
        GRANT_READ
    } grantT;

    stateT            state;
    grantT            lastGrant;
    logic [2:0]       latCnt;
    logic [TAG_W-1:0] tagLatch;
    logic             grantWrite;
    logic             grantRead;

    // Write wins when alone, on a same-row hazard, or when it is its round-robin turn.
    // Gating with nRST keeps a FIFO from being popped while the bank is held in reset.
    always_comb begin
        // NOTE: every signal assigned in always_comb gets a default first so no latch is inferred.
        grantWrite = 1'b0;
        grantRead  = 1'b0;
        if (nRST && state == IDLE) begin
            if (!wFIFO_empty &&
                (rFIFO_empty || wFIFO_row == rFIFO_row || lastGrant == GRANT_READ)) begin
                grantWrite = 1'b1;
            end else if (!rFIFO_empty) begin
                grantRead = 1'b1;
            end
        end
    end

    assign wFIFO_REN = grantWrite;
    assign rFIFO_REN = grantRead;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state      <= IDLE;
            lastGrant  <= GRANT_READ;
            latCnt     <= '0;
            tagLatch   <= '0;
            bank_en    <= 1'b0;
            bank_wen   <= 1'b0;
            bank_row   <= '0;
            bank_wdata <= '0;
            rsp_valid  <= 1'b0;
            rsp_data   <= '0;
            rsp_tag    <= '0;
            busy       <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every register
            // samples pre-edge values regardless of statement order.
            case (state)
                IDLE: begin
                    if (grantWrite) begin
                        bank_en    <= 1'b1;
                        bank_wen   <= 1'b1;
                        bank_row   <= wFIFO_row;
                        bank_wdata <= wFIFO_data;
                        lastGrant  <= GRANT_WRITE;
                        busy       <= 1'b1;
                        state      <= WRITE;
                    end else if (grantRead) begin
                        bank_en    <= 1'b1;
                        bank_wen   <= 1'b0;
                        bank_row   <= rFIFO_row;
                        tagLatch   <= rFIFO_tag;
                        lastGrant  <= GRANT_READ;
                        busy       <= 1'b1;
                        state      <= READ_ISSUE;
                    end
                end

                WRITE: begin
                    bank_en  <= 1'b0;
                    bank_wen <= 1'b0;
                    busy     <= 1'b0;
                    state    <= IDLE;
                end

                READ_ISSUE: begin
                    bank_en <= 1'b0;
                    latCnt  <= 3'(SRAM_LAT - 1);
                    state   <= READ_WAIT;
                end

                // latCnt reaches zero in the cycle the SRAM presents the row.
                READ_WAIT: begin
                    if (latCnt == 3'd0) begin
                        rsp_data  <= bank_rdata;
                        rsp_tag   <= tagLatch;
                        rsp_valid <= 1'b1;
                        state     <= RESP;
                    end else begin
                        latCnt <= latCnt - 3'd1;
                    end
                end

                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end
                end

                default: begin
                    bank_en   <= 1'b0;
                    rsp_valid <= 1'b0;
                    busy      <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sp_bank_responder.sv
// Bench for sp_bank_responder: show-ahead FIFO and SRAM models, a response scoreboard,
// a table of isolated transactions and hand-written multi-cycle sequences.
module tb_sp_bank_responder;

    localparam int ROW_W = 5;
    localparam int DW    = 64;
    localparam int TW    = 4;
    localparam int LAT   = 2;

    typedef struct packed {
        logic [ROW_W-1:0] row;
        logic [DW-1:0]    data;
    } wEntT;

    typedef struct packed {
        logic [ROW_W-1:0] row;
        logic [TW-1:0]    tag;
    } rEntT;

    typedef struct packed {
        logic [TW-1:0] tag;
        logic [DW-1:0] data;
    } rspT;

    typedef struct {
        logic             isWrite;
        logic [ROW_W-1:0] row;
        logic [DW-1:0]    data;
        logic [TW-1:0]    tag;
        logic [DW-1:0]    expData;
    } vecT;

    logic             CLK = 1'b0;
    logic             nRST;
    logic             wFIFO_empty;
    logic [ROW_W-1:0] wFIFO_row;
    logic [DW-1:0]    wFIFO_data;
    logic             wFIFO_REN;
    logic             rFIFO_empty;
    logic [ROW_W-1:0] rFIFO_row;
    logic [TW-1:0]    rFIFO_tag;
    logic             rFIFO_REN;
    logic             bank_en;
    logic             bank_wen;
    logic [ROW_W-1:0] bank_row;
    logic [DW-1:0]    bank_wdata;
    logic [DW-1:0]    bank_rdata;
    logic             rsp_valid;
    logic [DW-1:0]    rsp_data;
    logic [TW-1:0]    rsp_tag;
    logic             rsp_ready;
    logic             busy;

    always #5 CLK = ~CLK;

    sp_bank_responder #(
        .ROW_S_W(ROW_W), .BITS_PER_ROW(DW), .TAG_W(TW), .SRAM_LAT(LAT)
    ) dut (
        .CLK(CLK), .nRST(nRST),
        .wFIFO_empty(wFIFO_empty), .wFIFO_row(wFIFO_row), .wFIFO_data(wFIFO_data),
        .wFIFO_REN(wFIFO_REN),
        .rFIFO_empty(rFIFO_empty), .rFIFO_row(rFIFO_row), .rFIFO_tag(rFIFO_tag),
        .rFIFO_REN(rFIFO_REN),
        .bank_en(bank_en), .bank_wen(bank_wen), .bank_row(bank_row),
        .bank_wdata(bank_wdata), .bank_rdata(bank_rdata),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_tag(rsp_tag),
        .rsp_ready(rsp_ready), .busy(busy)
    );

    // SRAM model: unwritten rows read as 64'h1000+row, except row 7 which holds 64'h1234.
    logic [DW-1:0] mem [32];
    bit            written [32];
    logic [DW-1:0] pipe [LAT];

    function automatic logic [DW-1:0] readRow(input logic [ROW_W-1:0] r);
        if (written[r]) return mem[r];
        if (r == 5'd7) return 64'h1234;
        return 64'h1000 + 64'(r);
    endfunction

    always @(posedge CLK) begin
        if (bank_en && bank_wen) begin
            mem[bank_row]     <= bank_wdata;
            written[bank_row] <= 1'b1;
        end
        pipe[0] <= (bank_en && !bank_wen) ? readRow(bank_row) : 64'h0BAD_0BAD_0BAD_0BAD;
        for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
    end
    assign bank_rdata = pipe[LAT-1];

    wEntT wq [$];
    rEntT rq [$];
    rspT  sb [$];
    vecT  vecs [8];

    int errors = 0;
    int checks = 0;

    logic             sWren, sRren, sEn, sWen, sValid, sBusy;
    logic [ROW_W-1:0] sRow;
    logic [DW-1:0]    sWdata, sData;
    logic [TW-1:0]    sTag;
    logic [7:0]       popBits;
    int               popCnt;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic refresh();
        wFIFO_empty = (wq.size() == 0);
        wFIFO_row   = (wq.size() != 0) ? wq[0].row  : '0;
        wFIFO_data  = (wq.size() != 0) ? wq[0].data : '0;
        rFIFO_empty = (rq.size() == 0);
        rFIFO_row   = (rq.size() != 0) ? rq[0].row  : '0;
        rFIFO_tag   = (rq.size() != 0) ? rq[0].tag  : '0;
    endtask

    // One clock: snapshot outputs at the falling edge, score any handshake, then apply pops.
    task automatic cycle();
        rspT e;
        @(negedge CLK);
        sWren  = wFIFO_REN;
        sRren  = rFIFO_REN;
        sEn    = bank_en;
        sWen   = bank_wen;
        sRow   = bank_row;
        sWdata = bank_wdata;
        sValid = rsp_valid;
        sData  = rsp_data;
        sTag   = rsp_tag;
        sBusy  = busy;
        if (sWren || sRren) begin
            check("pop_legal", 64'({sWren & sRren, sWren & wFIFO_empty, sRren & rFIFO_empty}), 64'd0);
            if (popCnt < 8) popBits[popCnt] = sRren;
            popCnt++;
        end
        if (rsp_valid && rsp_ready) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL rsp_unexpected: got tag %0h data %0h, none expected", rsp_tag, rsp_data);
            end else begin
                e = sb.pop_front();
                check("rsp_tag", 64'(rsp_tag), 64'(e.tag));
                check("rsp_data", rsp_data, e.data);
            end
        end
        @(posedge CLK);
        #1;
        if (sWren && wq.size() != 0) wq.delete(0);
        if (sRren && rq.size() != 0) rq.delete(0);
        refresh();
    endtask

    task automatic drain(input string name);
        int n = 0;
        while ((n < 3 || sb.size() != 0 || wq.size() != 0 || rq.size() != 0 || sBusy) && n < 200) begin
            cycle();
            n++;
        end
        check(name, 64'(n < 200), 64'd1);
    endtask

    task automatic runVec(input vecT v);
        int n;
        if (v.isWrite) begin
            wq.push_back('{row: v.row, data: v.data});
            refresh();
            cycle();
            check("w_pop", 64'({sWren, sRren}), 64'(2'b10));
            cycle();
            check("w_bank_ctl", 64'({sEn, sWen, sBusy}), 64'(3'b111));
            check("w_bank_row", 64'(sRow), 64'(v.row));
            check("w_bank_wdata", sWdata, v.data);
            cycle();
            check("w_done", 64'({sEn, sBusy, sWren}), 64'd0);
            check("w_row_hold", 64'(sRow), 64'(v.row));
        end else begin
            rq.push_back('{row: v.row, tag: v.tag});
            sb.push_back('{tag: v.tag, data: v.expData});
            refresh();
            cycle();
            check("r_pop", 64'({sWren, sRren}), 64'(2'b01));
            cycle();
            check("r_bank_ctl", 64'({sEn, sWen, sBusy}), 64'(3'b101));
            check("r_bank_row", 64'(sRow), 64'(v.row));
            n = 1;
            while (!sValid && n < 20) begin
                cycle();
                n++;
            end
            check("r_latency", 64'(n), 64'(LAT + 2));
            cycle();
            check("r_done", 64'({sValid, sBusy}), 64'd0);
            check("r_sb_empty", 64'(sb.size()), 64'd0);
        end
    endtask

    initial begin
        int n;
        nRST      = 1'b0;
        rsp_ready = 1'b1;
        popBits   = '0;
        popCnt    = 0;
        refresh();

        vecs[0] = '{1'b1, 5'd3,  64'hDEAD_BEEF_0000_0001, 4'h0, 64'h0};
        vecs[1] = '{1'b0, 5'd7,  64'h0,                   4'hA, 64'h1234};
        vecs[2] = '{1'b0, 5'd3,  64'h0,                   4'h1, 64'hDEAD_BEEF_0000_0001};
        vecs[3] = '{1'b1, 5'd31, 64'hFFFF_FFFF_FFFF_FFFF, 4'h0, 64'h0};
        vecs[4] = '{1'b0, 5'd31, 64'h0,                   4'hF, 64'hFFFF_FFFF_FFFF_FFFF};
        vecs[5] = '{1'b0, 5'd0,  64'h0,                   4'h0, 64'h1000};
        vecs[6] = '{1'b1, 5'd0,  64'h0,                   4'h0, 64'h0};
        vecs[7] = '{1'b0, 5'd0,  64'h0,                   4'h5, 64'h0};

        // Reset state.
        repeat (3) cycle();
        check("rst_bank", 64'({sEn, sWen, sRow, sWdata}), 64'd0);
        check("rst_rsp", 64'({sValid, sTag}), 64'd0);
        check("rst_rsp_data", sData, 64'd0);
        check("rst_busy_ren", 64'({sBusy, sWren, sRren}), 64'd0);
        nRST = 1'b1;
        cycle();
        check("idle_after_rst", 64'({sBusy, sEn, sWren, sRren}), 64'd0);

        for (int i = 0; i < 8; i++) runVec(vecs[i]);

        // Backpressure: response held for 5 stalled cycles, queued read not popped.
        rsp_ready = 1'b0;
        rq.push_back('{row: 5'd7, tag: 4'h3});
        sb.push_back('{tag: 4'h3, data: 64'h1234});
        rq.push_back('{row: 5'd5, tag: 4'h6});
        sb.push_back('{tag: 4'h6, data: 64'h1005});
        refresh();
        n = 0;
        sValid = 1'b0;
        while (!sValid && n < 30) begin
            cycle();
            n++;
        end
        check("bp_valid_seen", 64'(sValid), 64'd1);
        for (int i = 0; i < 5; i++) begin
            cycle();
            check("bp_hold", 64'({sValid, sTag, sRren}), 64'({1'b1, 4'h3, 1'b0}));
            check("bp_hold_data", sData, 64'h1234);
        end
        rsp_ready = 1'b1;
        cycle();
        check("bp_handshake", 64'(sValid), 64'd1);
        cycle();
        check("bp_drop", 64'(sValid), 64'd0);
        drain("bp_drained");

        // Same-row hazard with lastGrant == WRITE: write still goes first.
        runVec('{1'b1, 5'd20, 64'h20, 4'h0, 64'h0});
        wq.push_back('{row: 5'd9, data: 64'h55});
        rq.push_back('{row: 5'd9, tag: 4'h2});
        sb.push_back('{tag: 4'h2, data: 64'h55});
        refresh();
        cycle();
        check("hazard_first_pop", 64'({sWren, sRren}), 64'(2'b10));
        drain("hazard_drained");

        // Round-robin from reset: W,R,W,R,W,R.
        nRST = 1'b0;
        cycle();
        nRST = 1'b1;
        cycle();
        for (int i = 0; i < 3; i++) begin
            wq.push_back('{row: 5'(10 + i), data: 64'hA000 + 64'(i)});
            rq.push_back('{row: 5'(13 + i), tag: 4'(6 + i)});
            sb.push_back('{tag: 4'(6 + i), data: 64'h100D + 64'(i)});
        end
        refresh();
        popBits = '0;
        popCnt  = 0;
        drain("rr_drained");
        check("rr_pop_count", 64'(popCnt), 64'd6);
        check("rr_order", 64'(popBits[5:0]), 64'(6'b101010));

        // Reset while in READ_WAIT: outputs clear at once, in-flight read is dropped.
        rq.push_back('{row: 5'd7, tag: 4'h4});
        sb.push_back('{tag: 4'h4, data: 64'h1234});
        refresh();
        cycle();
        check("mr_pop", 64'({sWren, sRren}), 64'(2'b01));
        cycle();
        cycle();
        check("mr_in_wait", 64'({sEn, sBusy, sValid}), 64'(3'b010));
        nRST = 1'b0;
        #1;
        check("mr_async_bank", 64'({bank_en, bank_wen, bank_row}), 64'd0);
        check("mr_async_wdata", bank_wdata, 64'd0);
        check("mr_async_rsp", 64'({rsp_valid, rsp_tag, busy, wFIFO_REN, rFIFO_REN}), 64'd0);
        check("mr_async_rdata", rsp_data, 64'd0);
        sb.delete();
        cycle();
        cycle();
        nRST = 1'b1;
        cycle();
        check("mr_post_idle", 64'({sValid, sBusy, sEn}), 64'd0);
        runVec('{1'b0, 5'd5, 64'h0, 4'h9, 64'h1005});

        check("final_sb_empty", 64'(sb.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

endmodule
